// File: rtl/esp_frame_ctrl.sv
// Packet controller for the ESP32 byte stream: sync hunt, header parse, payload
// sequencing into the frame-buffer write port, checksum check and timeout supervision.
module esp_frame_ctrl #(
   parameter int          ADDR_W      = 16,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int          TIMEOUT_CYC = 27000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              fb_wr_en,
   output logic [ADDR_W-1:0] fb_wr_addr,
   output logic [7:0]        fb_wr_data,
   input  logic              fb_wr_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic [15:0]       frame_len
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_CMD     = 4'd1;
   localparam logic [3:0] S_LEN_H   = 4'd2;
   localparam logic [3:0] S_LEN_L   = 4'd3;
   localparam logic [3:0] S_ADDR_H  = 4'd4;
   localparam logic [3:0] S_ADDR_L  = 4'd5;
   localparam logic [3:0] S_PAYLOAD = 4'd6;
   localparam logic [3:0] S_CHK     = 4'd7;
   localparam logic [3:0] S_FINISH  = 4'd8;

   localparam logic [7:0] CMD_PIXEL = 8'h01;
   localparam logic [7:0] CMD_PING  = 8'h02;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_CMD  = 2'd1;
   localparam logic [1:0] ERR_CHK  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

   localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic [3:0]        state_q, state_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [7:0]        len_hi_q, len_hi_d;
   logic [7:0]        addr_hi_q, addr_hi_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       rem_q, rem_d;
   logic [7:0]        chk_q, chk_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              fb_wr_en_q, fb_wr_en_d;
   logic [ADDR_W-1:0] fb_wr_addr_q, fb_wr_addr_d;
   logic [7:0]        fb_wr_data_q, fb_wr_data_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [15:0]       frame_len_q, frame_len_d;

   logic rx_accept_s;
   logic wr_clear_s;
   logic tmo_run_s;
   logic tmo_hit_s;

   // Byte acceptance: payload bytes only enter when the one-entry write slot frees up.
   always_comb begin
      rx_ready = 1'b1;
      case (state_q)
         S_PAYLOAD: rx_ready = !fb_wr_en_q || fb_wr_ready;
         S_FINISH:  rx_ready = 1'b0;
         default:   rx_ready = 1'b1;
      endcase
   end

   // Handshake and timeout qualifiers shared by the next-state logic.
   always_comb begin
      rx_accept_s = rx_valid && rx_ready;
      wr_clear_s  = !fb_wr_en_q || fb_wr_ready;
      tmo_run_s   = (state_q != S_IDLE) && (state_q != S_FINISH);
      tmo_hit_s   = tmo_run_s && !rx_accept_s && (tmo_q == TMO_LAST);
   end

   // Next-state, datapath and status computation.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      len_hi_d     = len_hi_q;
      addr_hi_d    = addr_hi_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      chk_d        = chk_q;
      fb_wr_addr_d = fb_wr_addr_q;
      fb_wr_data_d = fb_wr_data_q;
      err_code_d   = err_code_q;
      frame_len_d  = frame_len_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;

      // A pending write retires on its handshake regardless of packet state.
      if (fb_wr_en_q && fb_wr_ready) begin
         fb_wr_en_d = 1'b0;
      end else begin
         fb_wr_en_d = fb_wr_en_q;
      end

      if (!tmo_run_s || rx_accept_s) begin
         tmo_d = {TMO_W{1'b0}};
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      if (tmo_hit_s) begin
         state_d     = S_IDLE;
         frame_err_d = 1'b1;
         err_code_d  = ERR_TMO;
         tmo_d       = {TMO_W{1'b0}};
      end else if (rx_accept_s) begin
         case (state_q)
            S_IDLE: begin
               if (rx_data == SYNC_BYTE) begin
                  state_d    = S_CMD;
                  chk_d      = 8'h00;
                  err_code_d = ERR_NONE;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CMD: begin
               cmd_d = rx_data;
               chk_d = chk_q + rx_data;
               if ((rx_data == CMD_PIXEL) || (rx_data == CMD_PING)) begin
                  state_d = S_LEN_H;
               end else begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CMD;
               end
            end
            S_LEN_H: begin
               len_hi_d = rx_data;
               chk_d    = chk_q + rx_data;
               state_d  = S_LEN_L;
            end
            S_LEN_L: begin
               frame_len_d = {len_hi_q, rx_data};
               chk_d       = chk_q + rx_data;
               state_d     = S_ADDR_H;
            end
            S_ADDR_H: begin
               addr_hi_d = rx_data;
               chk_d     = chk_q + rx_data;
               state_d   = S_ADDR_L;
            end
            S_ADDR_L: begin
               addr_d = ADDR_W'({addr_hi_q, rx_data});
               chk_d  = chk_q + rx_data;
               if ((cmd_q == CMD_PIXEL) && (frame_len_q != 16'd0)) begin
                  rem_d   = frame_len_q;
                  state_d = S_PAYLOAD;
               end else begin
                  state_d = S_CHK;
               end
            end
            S_PAYLOAD: begin
               fb_wr_en_d   = 1'b1;
               fb_wr_addr_d = addr_q;
               fb_wr_data_d = rx_data;
               addr_d       = addr_q + ADDR_W'(1);
               rem_d        = rem_q - 16'd1;
               chk_d        = chk_q + rx_data;
               if (rem_q == 16'd1) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
            S_CHK: begin
               if (rx_data != chk_q) begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
               end else if (wr_clear_s) begin
                  state_d      = S_IDLE;
                  frame_done_d = 1'b1;
               end else begin
                  state_d = S_FINISH;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q == S_FINISH) begin
         // Done is reported only once the last payload write has been taken.
         if (wr_clear_s) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
         end else begin
            state_d = S_FINISH;
         end
      end else begin
         state_d = state_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cmd_q        <= 8'h00;
         len_hi_q     <= 8'h00;
         addr_hi_q    <= 8'h00;
         addr_q       <= {ADDR_W{1'b0}};
         rem_q        <= 16'd0;
         chk_q        <= 8'h00;
         tmo_q        <= {TMO_W{1'b0}};
         fb_wr_en_q   <= 1'b0;
         fb_wr_addr_q <= {ADDR_W{1'b0}};
         fb_wr_data_q <= 8'h00;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= ERR_NONE;
         frame_len_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         len_hi_q     <= len_hi_d;
         addr_hi_q    <= addr_hi_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         chk_q        <= chk_d;
         tmo_q        <= tmo_d;
         fb_wr_en_q   <= fb_wr_en_d;
         fb_wr_addr_q <= fb_wr_addr_d;
         fb_wr_data_q <= fb_wr_data_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
         frame_len_q  <= frame_len_d;
      end
   end

   assign fb_wr_en   = fb_wr_en_q;
   assign fb_wr_addr = fb_wr_addr_q;
   assign fb_wr_data = fb_wr_data_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign err_code   = err_code_q;
   assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_esp_frame_ctrl.sv
// Scoreboard bench for esp_frame_ctrl: expected writes and status events are queued
// as packets are driven and retired by a monitor on the falling clock edge.
module tb_esp_frame_ctrl;

   localparam int TMO = 27000;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        fb_wr_en;
   logic [15:0] fb_wr_addr;
   logic [7:0]  fb_wr_data;
   logic        fb_wr_ready;
   logic        busy;
   logic        frame_done;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [15:0] frame_len;

   esp_frame_ctrl #(
      .ADDR_W(16),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .fb_wr_en(fb_wr_en),
      .fb_wr_addr(fb_wr_addr),
      .fb_wr_data(fb_wr_data),
      .fb_wr_ready(fb_wr_ready),
      .busy(busy),
      .frame_done(frame_done),
      .frame_err(frame_err),
      .err_code(err_code),
      .frame_len(frame_len)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [23:0] wr_q[$];
   logic [3:0]  ev_q[$];
   logic [7:0]  pl[0:15];
   int          ready_mode = 0;
   int          cyc = 0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_addr = 16'h0;
   logic [7:0]  prev_data = 8'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // fb_wr_ready pattern: 0 = always ready, 1 = one low / two high, 2 = stalled
   always @(posedge clk) begin
      #1;
      cyc++;
      case (ready_mode)
         1:       fb_wr_ready = (cyc % 3 != 0);
         2:       fb_wr_ready = 1'b0;
         default: fb_wr_ready = 1'b1;
      endcase
   end

   // Monitor: retire writes/events against the scoreboard and check stall stability
   always @(negedge clk) begin
      logic [23:0] w;
      logic [3:0]  e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("stall_en", 32'(fb_wr_en), 32'd1);
            check_eq("stall_addr", 32'(fb_wr_addr), 32'(prev_addr));
            check_eq("stall_data", 32'(fb_wr_data), 32'(prev_data));
         end
         if (fb_wr_en && fb_wr_ready) begin
            if (wr_q.size() == 0) begin
               check_eq("unexpected_write", 32'(wr_q.size()), 32'd1);
            end else begin
               w = wr_q.pop_front();
               check_eq("write_addr_data", {8'h00, fb_wr_addr, fb_wr_data}, {8'h00, w});
            end
         end
         prev_stall = fb_wr_en && !fb_wr_ready;
         prev_addr  = fb_wr_addr;
         prev_data  = fb_wr_data;
         if (frame_done || frame_err) begin
            check_eq("done_err_exclusive", 32'(frame_done && frame_err), 32'd0);
            if (ev_q.size() == 0) begin
               check_eq("unexpected_event", 32'(ev_q.size()), 32'd1);
            end else begin
               e = ev_q.pop_front();
               check_eq("event_kind", 32'({frame_done, frame_err}), 32'(e[3:2]));
               check_eq("event_code", 32'(err_code), 32'(e[1:0]));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      acc      = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 2000 && !acc; i++) begin
         @(negedge clk);
         acc = rx_ready;
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
      check_eq("rx_accept", 32'(acc), 32'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 500; i++) begin
         if (ev_q.size() == 0 && wr_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check_eq("drain_events", 32'(ev_q.size()), 32'd0);
      check_eq("drain_writes", 32'(wr_q.size()), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic send_packet(input logic [7:0] cmd, input logic [15:0] len,
                              input logic [15:0] addr, input int n,
                              input logic [7:0] chk_adj, input logic [1:0] exp_code);
      logic [7:0]  chk;
      logic [15:0] a;
      chk = cmd + len[15:8] + len[7:0] + addr[15:8] + addr[7:0];
      a   = addr;
      for (int i = 0; i < n; i++) begin
         chk = chk + pl[i];
         if (cmd == 8'h01) begin
            wr_q.push_back({a, pl[i]});
            a = a + 16'd1;
         end
      end
      ev_q.push_back((exp_code == 2'd0) ? 4'b1000 : {2'b01, exp_code});
      send_byte(8'hA5);
      send_byte(cmd);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
      for (int i = 0; i < n; i++) send_byte(pl[i]);
      send_byte(chk + chk_adj);
      wait_drain();
   endtask

   initial begin
      int k_lat;
      rst         = 1'b1;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      fb_wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_wr_en", 32'(fb_wr_en), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done_err", 32'({frame_done, frame_err}), 32'd0);
      check_eq("rst_err_code", 32'(err_code), 32'd0);
      check_eq("rst_frame_len", 32'(frame_len), 32'd0);
      check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1;

      // Pixel write, always ready
      pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF;
      send_packet(8'h01, 16'h0004, 16'h0010, 4, 8'h00, 2'd0);
      check_eq("pix_frame_len", 32'(frame_len), 32'd4);
      check_eq("pix_err_code", 32'(err_code), 32'd0);

      // Same packet under backpressure
      ready_mode = 1;
      send_packet(8'h01, 16'h0004, 16'h0010, 4, 8'h00, 2'd0);
      ready_mode = 0;

      // Address wrap
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_packet(8'h01, 16'h0003, 16'hFFFE, 3, 8'h00, 2'd0);

      // Bad checksum, bad command, then a good ping
      pl[0] = 8'h5A; pl[1] = 8'hC3;
      send_packet(8'h01, 16'h0002, 16'h0200, 2, 8'h01, 2'd2);
      pl[0] = 8'h55;
      send_packet(8'h07, 16'h0001, 16'h0000, 1, 8'h00, 2'd1);
      send_packet(8'h02, 16'h0000, 16'h0000, 0, 8'h00, 2'd0);
      check_eq("ping_err_code", 32'(err_code), 32'd0);

      // Timeout after a partial header
      ev_q.push_back({2'b01, 2'd3});
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      check_eq("busy_mid", 32'(busy), 32'd1);
      k_lat = 0;
      for (int k = 1; k <= TMO + 20; k++) begin
         @(negedge clk);
         k_lat = k;
         if (frame_err) break;
      end
      check_eq("tmo_window", 32'((k_lat >= TMO - 2) && (k_lat <= TMO + 3)), 32'd1);
      check_eq("tmo_err_code", 32'(err_code), 32'd3);
      @(posedge clk);
      #1;
      wait_drain();

      // Leading garbage then a ping
      send_byte(8'h00);
      send_byte(8'hFF);
      send_packet(8'h02, 16'h0000, 16'h0000, 0, 8'h00, 2'd0);

      // Reset while a payload write is stalled
      ready_mode = 2;
      @(posedge clk);
      #1;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h20);
      send_byte(8'h77);
      repeat (3) @(posedge clk);
      #1;
      check_eq("stalled_wr_en", 32'(fb_wr_en), 32'd1);
      check_eq("stalled_rx_ready", 32'(rx_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      ready_mode = 0;
      @(negedge clk);
      check_eq("mrst_wr_en", 32'(fb_wr_en), 32'd0);
      check_eq("mrst_wr_addr_data", 32'({fb_wr_addr, fb_wr_data}), 32'd0);
      check_eq("mrst_busy", 32'(busy), 32'd0);
      check_eq("mrst_status", 32'({frame_done, frame_err, err_code}), 32'd0);
      check_eq("mrst_frame_len", 32'(frame_len), 32'd0);
      check_eq("mrst_rx_ready", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1;

      // Good packet after reset; sync value inside payload is data
      pl[0] = 8'hA5; pl[1] = 8'h5A;
      send_packet(8'h01, 16'h0002, 16'h0100, 2, 8'h00, 2'd0);
      check_eq("post_frame_len", 32'(frame_len), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
